// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - Shared SRAM widths, frame size and controller state encoding
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int FRAME_WORDS = 38400;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ACCESS = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_PULSE  = 3'd3,
        ST_WR_HOLD   = 3'd4
    } sram_state_t;

    // Width needed to hold a down-counter loaded with (cycles - 1).
    function automatic int cycle_cnt_width(input int read_cycles, input int write_cycles);
        int max_cycles;
        max_cycles = (read_cycles > write_cycles) ? read_cycles : write_cycles;
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - Single-word read/write sequencer for a 256Kx16 asynchronous SRAM
module sram_controller
    import sram_pkg::*;
#(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SRAM_ADDR_W-1:0] address,
    input  logic [SRAM_DATA_W-1:0] data_write,
    input  logic                   read,
    input  logic                   write,
    output logic                   ready,
    output logic [SRAM_DATA_W-1:0] data_read,
    output logic [SRAM_ADDR_W-1:0] sram_address,
    output logic [SRAM_DATA_W-1:0] sram_data_out,
    output logic                   sram_data_oe,
    input  logic [SRAM_DATA_W-1:0] sram_data_in,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_lb_n,
    output logic                   sram_ub_n
);

    localparam int               CNT_W   = cycle_cnt_width(READ_CYCLES, WRITE_CYCLES);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

    sram_state_t            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ready;
    logic [SRAM_DATA_W-1:0] r_data_read;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [SRAM_DATA_W-1:0] r_dout;
    logic                   r_doe;
    logic                   r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_data_read <= '0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_doe       <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_doe   <= 1'b0;
                    // Write wins over a simultaneous read; the read is dropped.
                    if (r_ready && write) begin
                        r_addr  <= address;
                        r_dout  <= data_write;
                        r_ce_n  <= 1'b0;
                        r_doe   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= ST_WR_SETUP;
                    end else if (r_ready && read) begin
                        r_addr  <= address;
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= 1'b0;
                        r_ready <= 1'b0;
                        r_cnt   <= RD_LOAD;
                        r_state <= ST_RD_ACCESS;
                    end
                end
                ST_RD_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_data_read <= sram_data_in;
                        r_ce_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= WR_LOAD;
                    r_state <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (r_cnt == '0) begin
                        r_we_n  <= 1'b1;
                        r_state <= ST_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    // Data stays driven one clock past the WE rising edge.
                    r_doe   <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_doe   <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready         = r_ready;
    assign data_read     = r_data_read;
    assign sram_address  = r_addr;
    assign sram_data_out = r_dout;
    assign sram_data_oe  = r_doe;
    assign sram_ce_n     = r_ce_n;
    assign sram_oe_n     = r_oe_n;
    assign sram_we_n     = r_we_n;
    assign sram_lb_n     = 1'b0;
    assign sram_ub_n     = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - Scoreboard bench for sram_controller with an SRAM array model
module tb_sram_controller;

    localparam int RD_C = 2;
    localparam int WR_C = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wdata;

    logic        m_ready, m_doe, m_ce_n, m_oe_n, m_we_n, m_lb_n, m_ub_n;
    logic [15:0] m_data_read, m_dout, m_din;
    logic [17:0] m_addr;

    logic        f_ready, f_doe, f_ce_n, f_oe_n, f_we_n, f_lb_n, f_ub_n;
    logic [15:0] f_data_read, f_dout;
    logic [17:0] f_addr;

    logic        s_ready, s_doe, s_ce_n, s_oe_n, s_we_n, s_lb_n, s_ub_n;
    logic [15:0] s_data_read, s_dout;
    logic [17:0] s_addr;

    logic [15:0] pad_const = 16'h5A5A;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          oe_low = 0;
    int          we_low = 0;
    int          doe_cnt = 0;
    int          overlap = 0;

    logic [15:0] mem [0:262143];

    always #5 clk = ~clk;

    sram_controller u_dut (
        .clk(clk), .reset(reset), .address(addr), .data_write(wdata),
        .read(rd), .write(wr), .ready(m_ready), .data_read(m_data_read),
        .sram_address(m_addr), .sram_data_out(m_dout), .sram_data_oe(m_doe),
        .sram_data_in(m_din), .sram_ce_n(m_ce_n), .sram_oe_n(m_oe_n),
        .sram_we_n(m_we_n), .sram_lb_n(m_lb_n), .sram_ub_n(m_ub_n)
    );

    sram_controller #(.READ_CYCLES(1), .WRITE_CYCLES(1)) u_fast (
        .clk(clk), .reset(reset), .address(addr), .data_write(wdata),
        .read(rd), .write(wr), .ready(f_ready), .data_read(f_data_read),
        .sram_address(f_addr), .sram_data_out(f_dout), .sram_data_oe(f_doe),
        .sram_data_in(pad_const), .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n),
        .sram_we_n(f_we_n), .sram_lb_n(f_lb_n), .sram_ub_n(f_ub_n)
    );

    sram_controller #(.READ_CYCLES(3), .WRITE_CYCLES(4)) u_slow (
        .clk(clk), .reset(reset), .address(addr), .data_write(wdata),
        .read(rd), .write(wr), .ready(s_ready), .data_read(s_data_read),
        .sram_address(s_addr), .sram_data_out(s_dout), .sram_data_oe(s_doe),
        .sram_data_in(pad_const), .sram_ce_n(s_ce_n), .sram_oe_n(s_oe_n),
        .sram_we_n(s_we_n), .sram_lb_n(s_lb_n), .sram_ub_n(s_ub_n)
    );

    // Asynchronous SRAM model: reads while CE and OE low, writes while CE and WE low.
    assign m_din = (!m_ce_n && !m_oe_n) ? mem[m_addr] : 16'h0000;
    always @(posedge clk) begin
        if (!m_ce_n && !m_we_n) mem[m_addr] <= m_dout;
    end

    always @(negedge clk) begin
        if (m_oe_n === 1'b0) oe_low++;
        if (m_we_n === 1'b0) we_low++;
        if (m_doe === 1'b1) doe_cnt++;
        if (m_oe_n === 1'b0 && m_doe === 1'b1) overlap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_main_ready();
        int n = 0;
        while (m_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (m_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", m_ready, n);
        end
    endtask

    task automatic start_read(input logic [17:0] a, input logic [15:0] exp);
        addr = a; rd = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic start_write(input logic [17:0] a, input logic [15:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (m_ready === 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", m_ready); end
        checks++; if (m_data_read !== 16'h0) begin errors++; $display("FAIL rst_data_read: got %h required 0000", m_data_read); end
        checks++; if (m_addr !== 18'h0) begin errors++; $display("FAIL rst_address: got %h required 00000", m_addr); end
        checks++; if (m_dout !== 16'h0 || m_doe !== 1'b0) begin errors++; $display("FAIL rst_bus: dout=%h oe=%b required 0000/0", m_dout, m_doe); end
        checks++; if ({m_ce_n, m_oe_n, m_we_n} !== 3'b111) begin errors++; $display("FAIL rst_strobes: got %b required 111", {m_ce_n, m_oe_n, m_we_n}); end
        checks++; if ({m_lb_n, m_ub_n} !== 2'b00) begin errors++; $display("FAIL byte_lanes: got %b required 00", {m_lb_n, m_ub_n}); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", m_ready); end
        checks++; if ({m_ce_n, m_oe_n, m_we_n} !== 3'b111) begin errors++; $display("FAIL rst_release_strobes: got %b required 111", {m_ce_n, m_oe_n, m_we_n}); end
    endtask

    task automatic test_single_read();
        int n;
        logic [15:0] exp;
        wait_main_ready();
        oe_low = 0; doe_cnt = 0;
        start_read(18'h00050, 16'hA5C3);
        count_busy(n);
        exp = exp_q.pop_front();
        checks++; if (n !== RD_C) begin errors++; $display("FAIL read_ready_low: got %0d cycles required %0d", n, RD_C); end
        checks++; if (oe_low !== RD_C) begin errors++; $display("FAIL read_oe_low: got %0d cycles required %0d", oe_low, RD_C); end
        checks++; if (m_data_read !== exp) begin errors++; $display("FAIL read_data: got %h required %h", m_data_read, exp); end
        checks++; if (doe_cnt !== 0) begin errors++; $display("FAIL read_data_oe: driven %0d cycles required 0", doe_cnt); end
    endtask

    task automatic test_write_read();
        int n = 0;
        int stab_err = 0;
        int pat_err = 0;
        logic [15:0] exp;
        wait_main_ready();
        we_low = 0; overlap = 0;
        start_write(18'h12C00, 16'h1234);
        addr = 18'h0; wdata = 16'hFFFF;
        while (m_ready === 1'b0 && n < 50) begin
            if (m_addr !== 18'h12C00 || m_dout !== 16'h1234 || m_doe !== 1'b1) stab_err++;
            if ((m_we_n === 1'b0) !== (n >= 1 && n <= WR_C)) pat_err++;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== WR_C + 2) begin errors++; $display("FAIL write_ready_low: got %0d cycles required %0d", n, WR_C + 2); end
        checks++; if (we_low !== WR_C) begin errors++; $display("FAIL write_we_low: got %0d cycles required %0d", we_low, WR_C); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL write_stability: %0d unstable cycles required 0", stab_err); end
        checks++; if (pat_err !== 0) begin errors++; $display("FAIL write_we_window: %0d misplaced cycles required 0", pat_err); end
        checks++; if (m_doe !== 1'b0) begin errors++; $display("FAIL write_release: data_oe=%b required 0", m_doe); end
        start_read(18'h12C00, 16'h1234);
        count_busy(n);
        exp = exp_q.pop_front();
        checks++; if (m_data_read !== exp) begin errors++; $display("FAIL readback: got %h required %h", m_data_read, exp); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL oe_overlap: %0d cycles required 0", overlap); end
    endtask

    task automatic test_busy_strobes();
        int n;
        int dips = 0;
        logic [15:0] exp;
        wait_main_ready();
        oe_low = 0; we_low = 0;
        start_write(18'h00100, 16'hBEEF);
        rd = 1'b1; addr = 18'h00050;
        @(negedge clk);
        rd = 1'b0;
        wait_main_ready();
        for (int i = 0; i < 3; i++) begin
            if (m_ready !== 1'b1) dips++;
            @(negedge clk);
        end
        checks++; if (oe_low !== 0) begin errors++; $display("FAIL busy_read_dropped: oe low %0d cycles required 0", oe_low); end
        checks++; if (dips !== 0) begin errors++; $display("FAIL busy_read_queued: ready dropped %0d cycles required 0", dips); end
        checks++; if (we_low !== WR_C) begin errors++; $display("FAIL busy_write_we: got %0d required %0d", we_low, WR_C); end
        oe_low = 0; we_low = 0;
        addr = 18'h00200; wdata = 16'hC0DE; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        count_busy(n);
        checks++; if (n !== WR_C + 2) begin errors++; $display("FAIL both_busy: got %0d cycles required %0d", n, WR_C + 2); end
        checks++; if (oe_low !== 0 || we_low !== WR_C) begin errors++; $display("FAIL both_write_only: oe_low=%0d we_low=%0d required 0/%0d", oe_low, we_low, WR_C); end
        start_read(18'h00200, 16'hC0DE);
        count_busy(n);
        exp = exp_q.pop_front();
        checks++; if (m_data_read !== exp) begin errors++; $display("FAIL both_readback: got %h required %h", m_data_read, exp); end
        start_read(18'h00100, 16'hBEEF);
        count_busy(n);
        exp = exp_q.pop_front();
        checks++; if (m_data_read !== exp) begin errors++; $display("FAIL busy_write_readback: got %h required %h", m_data_read, exp); end
    endtask

    task automatic test_param_sweep();
        int nf, ns, nm, w;
        w = 0;
        while (!(m_ready === 1'b1 && f_ready === 1'b1 && s_ready === 1'b1) && w < 50) begin
            @(negedge clk);
            w++;
        end
        nf = 0; ns = 0;
        start_read(18'h00000, 16'h0000);
        void'(exp_q.pop_back());
        for (int i = 0; i < 10; i++) begin
            if (f_ready === 1'b0) nf++;
            if (s_ready === 1'b0) ns++;
            @(negedge clk);
        end
        checks++; if (nf !== 1) begin errors++; $display("FAIL sweep_read_rc1: got %0d cycles required 1", nf); end
        checks++; if (ns !== 3) begin errors++; $display("FAIL sweep_read_rc3: got %0d cycles required 3", ns); end
        checks++; if (s_data_read !== 16'h5A5A) begin errors++; $display("FAIL sweep_read_data: got %h required 5a5a", s_data_read); end
        nf = 0; ns = 0; nm = 0;
        start_write(18'h3FFFF, 16'h7777);
        for (int i = 0; i < 12; i++) begin
            if (f_ready === 1'b0) nf++;
            if (s_ready === 1'b0) ns++;
            if (m_ready === 1'b0) nm++;
            @(negedge clk);
        end
        checks++; if (nf !== 3) begin errors++; $display("FAIL sweep_write_wc1: got %0d cycles required 3", nf); end
        checks++; if (ns !== 6) begin errors++; $display("FAIL sweep_write_wc4: got %0d cycles required 6", ns); end
        checks++; if (nm !== 4) begin errors++; $display("FAIL sweep_write_default: got %0d cycles required 4", nm); end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        logic [15:0] exp;
        wait_main_ready();
        start_write(18'h00300, 16'h4444);
        while (m_we_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (m_we_n !== 1'b0) begin errors++; $display("FAIL midrst_pulse: we_n=%b required 0", m_we_n); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({m_ce_n, m_oe_n, m_we_n} !== 3'b111 || m_doe !== 1'b0) begin errors++; $display("FAIL midrst_strobes: strobes=%b oe=%b required 111/0", {m_ce_n, m_oe_n, m_we_n}, m_doe); end
        checks++; if (m_ready !== 1'b0 || m_data_read !== 16'h0) begin errors++; $display("FAIL midrst_clear: ready=%b data_read=%h required 0/0000", m_ready, m_data_read); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: ready=%b required 1", m_ready); end
        start_read(18'h12C00, 16'h1234);
        count_busy(n);
        exp = exp_q.pop_front();
        checks++; if (m_data_read !== exp) begin errors++; $display("FAIL midrst_readback: got %h required %h", m_data_read, exp); end
    endtask

    initial begin
        mem[18'h00050] = 16'hA5C3;
        test_reset();
        test_single_read();
        test_write_read();
        test_busy_strobes();
        test_param_sweep();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
